// File: rtl/color_evaluator_pkg.sv
// color_evaluator_pkg: shared colour encoding and evaluator FSM states
package color_evaluator_pkg;
  typedef enum logic [1:0] {
    COL_GREY   = 2'b00,
    COL_YELLOW = 2'b01,
    COL_GREEN  = 2'b10,
    COL_BLANK  = 2'b11
  } color_t;
  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_EVAL, S_DONE} eval_state_t;
  localparam int N_POS = 5;
  localparam logic [9:0] ALL_BLANK = 10'h3FF;
  function automatic logic [2:0] popcount5(input logic [4:0] m);
    return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]) + 3'(m[4]);
  endfunction
endpackage

// File: rtl/color_evaluator_if.sv
// color_evaluator_if: request/result bundle between game controller and colour evaluator
interface color_evaluator_if;
  logic        start;
  logic [2:0]  guess_index;
  logic [2:0]  word_index;
  logic [24:0] cross_match_matrix;
  logic [24:0] self_match_matrix;
  logic        busy;
  logic        done;
  logic [9:0]  colors;
  logic        win;
  modport master (
    output start, guess_index, cross_match_matrix, self_match_matrix,
    input  word_index, busy, done, colors, win
  );
  modport slave (
    input  start, guess_index, cross_match_matrix, self_match_matrix,
    output word_index, busy, done, colors, win
  );
endinterface

// File: rtl/color_evaluator_match_counter.sv
// match_counter: population count of a 5-bit match mask
module match_counter
  import color_evaluator_pkg::*;
(
  input  logic [4:0] mask,
  output logic [2:0] count
);
  assign count = popcount5(mask);
endmodule

// File: rtl/color_evaluator.sv
// color_evaluator: resolves grey/yellow/green for one guess row, one position per cycle
module color_evaluator
  import color_evaluator_pkg::*;
(
  input logic clk,
  input logic rst,
  color_evaluator_if.slave bus
);
  eval_state_t state_q, state_d;
  logic [2:0]  cnt_q, cnt_d, word_index_q, word_index_d;
  logic [24:0] cross_q, cross_d, self_q, self_d;
  logic [4:0]  g_q, g_d, diag, cross_row, self_row, lower;
  logic [9:0]  colors_q, colors_d;
  logic        win_q, win_d, accept;
  logic [2:0]  avail, used;
  color_t      pos_color;
  match_counter u_avail (.mask(cross_row & ~g_q), .count(avail));
  match_counter u_used  (.mask(self_row & ~g_q & lower), .count(used));
  // row of the stored matrices for the position under evaluation, and the k<i mask
  always_comb begin
    cross_row = 5'(cross_q >> (5 * cnt_q));
    self_row  = 5'(self_q >> (5 * cnt_q));
    lower     = (5'd1 << cnt_q) - 5'd1;
    accept    = bus.start && bus.guess_index != 3'd0 && bus.guess_index != 3'd7;
    pos_color = g_q[cnt_q] ? COL_GREEN : (used < avail ? COL_YELLOW : COL_GREY);
    for (int i = 0; i < N_POS; i++) diag[i] = bus.cross_match_matrix[6*i];
  end
  // next-state and datapath updates
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    word_index_d = word_index_q;
    cross_d      = cross_q;
    self_d       = self_q;
    g_d          = g_q;
    colors_d     = colors_q;
    win_d        = win_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d      = S_CAPTURE;
        word_index_d = bus.guess_index;
        colors_d     = ALL_BLANK;
        win_d        = 1'b0;
      end
      S_CAPTURE: begin
        state_d = S_EVAL;
        cross_d = bus.cross_match_matrix;
        self_d  = bus.self_match_matrix;
        g_d     = diag;
        cnt_d   = 3'd0;
      end
      S_EVAL: begin
        for (int i = 0; i < N_POS; i++) if (cnt_q == 3'(i)) colors_d[2*i +: 2] = pos_color;
        if (cnt_q == 3'd4) begin
          state_d = S_DONE;
          win_d   = &g_q;
        end else cnt_d = cnt_q + 3'd1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state registers, asynchronous reset aborts any evaluation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      word_index_q <= 3'd0;
      cross_q      <= '0;
      self_q       <= '0;
      g_q          <= '0;
      colors_q     <= ALL_BLANK;
      win_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      word_index_q <= word_index_d;
      cross_q      <= cross_d;
      self_q       <= self_d;
      g_q          <= g_d;
      colors_q     <= colors_d;
      win_q        <= win_d;
    end
  end
  assign bus.busy       = state_q != S_IDLE;
  assign bus.done       = state_q == S_DONE;
  assign bus.word_index = word_index_q;
  assign bus.colors     = colors_q;
  assign bus.win        = win_q;
endmodule

// File: tb/tb_color_evaluator.sv
// tb_color_evaluator: scoreboard bench for the colour evaluator
module tb_color_evaluator;
  import color_evaluator_pkg::*;
  typedef struct {
    logic [2:0] idx;
    logic [9:0] colors;
    logic       win;
    int         t0;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t got_e;
  color_evaluator_if bus();
  color_evaluator dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] letter(input logic [39:0] w, input int i);
    return w[8*(4-i) +: 8];
  endfunction
  function automatic logic [24:0] match_m(input logic [39:0] a, input logic [39:0] b);
    logic [24:0] m = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) m[5*i+j] = letter(a, i) == letter(b, j);
    return m;
  endfunction
  function automatic logic [9:0] model(input logic [39:0] sol, input logic [39:0] gw);
    logic [9:0] r = '1;
    int cnt[256];
    for (int i = 0; i < 256; i++) cnt[i] = 0;
    for (int i = 0; i < 5; i++)
      if (letter(gw, i) == letter(sol, i)) r[2*i +: 2] = COL_GREEN;
      else cnt[letter(sol, i)]++;
    for (int i = 0; i < 5; i++)
      if (letter(gw, i) != letter(sol, i)) begin
        if (cnt[letter(gw, i)] > 0) begin
          r[2*i +: 2] = COL_YELLOW;
          cnt[letter(gw, i)]--;
        end else r[2*i +: 2] = COL_GREY;
      end
    return r;
  endfunction
  always @(negedge clk) if (bus.done === 1'b1) begin
    if (sb.size() == 0) check("spurious_done", 1, 0);
    else begin
      got_e = sb.pop_front();
      check("colors", 32'(bus.colors), 32'(got_e.colors));
      check("win", 32'(bus.win), 32'(got_e.win));
      check("word_index", 32'(bus.word_index), 32'(got_e.idx));
      check("latency", cyc - got_e.t0, 7);
    end
  end
  task automatic issue(input logic [39:0] sol, input logic [39:0] gw, input logic [2:0] idx);
    exp_t e;
    @(negedge clk);
    bus.cross_match_matrix = match_m(gw, sol);
    bus.self_match_matrix  = match_m(gw, gw);
    bus.guess_index = idx;
    bus.start = 1'b1;
    e.idx = idx; e.colors = model(sol, gw); e.win = sol == gw; e.t0 = cyc;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 1);
    check("colors_blank", 32'(bus.colors), 32'(ALL_BLANK));
  endtask
  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.done;
    end
    if (!seen) begin
      check("done_timeout", 0, 1);
      sb.delete();
    end
    @(negedge clk);
    check("busy_idle", 32'(bus.busy), 0);
  endtask
  task automatic run(input logic [39:0] sol, input logic [39:0] gw, input logic [2:0] idx);
    issue(sol, gw, idx);
    @(negedge clk);
    bus.cross_match_matrix = 25'($urandom);
    bus.self_match_matrix  = 25'($urandom);
    wait_done();
  endtask
  initial begin
    logic [39:0] s, g;
    bus.start = 1'b0;
    bus.guess_index = 3'd0;
    bus.cross_match_matrix = '0;
    bus.self_match_matrix = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_colors", 32'(bus.colors), 32'(ALL_BLANK));
    check("rst_win", 32'(bus.win), 0);
    check("rst_word_index", 32'(bus.word_index), 0);
    rst = 1'b0;
    run("CRANE", "CRANE", 3'd1);
    check("crane_colors", 32'(bus.colors), 32'h2AA);
    check("crane_win_hold", 32'(bus.win), 1);
    run("APPLE", "PAPER", 3'd2);
    check("paper_colors", 32'(bus.colors), 32'h065);
    check("paper_win", 32'(bus.win), 0);
    run("ABBEY", "BOBBY", 3'd6);
    check("bobby_colors", 32'(bus.colors), 32'h221);
    issue("ABBEY", "BOBBY", 3'd3);
    repeat (2) @(negedge clk);
    bus.guess_index = 3'd5;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_start_word_index", 32'(bus.word_index), 3);
    wait_done();
    repeat (10) @(negedge clk);
    check("busy_start_colors", 32'(bus.colors), 32'h221);
    issue("APPLE", "PAPER", 3'd4);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_colors", 32'(bus.colors), 32'(ALL_BLANK));
    check("abort_done", 32'(bus.done), 0);
    check("abort_word_index", 32'(bus.word_index), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    run("APPLE", "PAPER", 3'd4);
    check("restart_colors", 32'(bus.colors), 32'h065);
    foreach (g[i]) g[i] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.guess_index = k == 0 ? 3'd0 : 3'd7;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("bad_index_busy", 32'(bus.busy), 0);
      repeat (9) @(negedge clk);
      check("bad_index_busy_late", 32'(bus.busy), 0);
    end
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 5; i++) begin
        s[8*i +: 8] = 8'h41 + 8'($urandom_range(0, 3));
        g[8*i +: 8] = 8'h41 + 8'($urandom_range(0, 3));
      end
      run(s, g, 3'($urandom_range(1, 6)));
    end
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
